slb_mem_ctrl: RTL and testbench



---
 rtl/slb_mem_ctrl_pkg.sv | 38 +++
 rtl/slb_mem_ctrl_ext.sv | 26 ++
 rtl/slb_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_slb_mem_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slb_mem_ctrl_pkg.sv
// Shared definitions for slb_mem_ctrl: memory opcodes, controller states,
// access-size decode and the IO address-space tag.
package mem_ctrl_pkg;

   localparam int OP_BITS = 6;

   localparam logic [OP_BITS-1:0] OP_LB  = 6'd0;
   localparam logic [OP_BITS-1:0] OP_LH  = 6'd1;
   localparam logic [OP_BITS-1:0] OP_LW  = 6'd2;
   localparam logic [OP_BITS-1:0] OP_LBU = 6'd3;
   localparam logic [OP_BITS-1:0] OP_LHU = 6'd4;
   localparam logic [OP_BITS-1:0] OP_SB  = 6'd5;
   localparam logic [OP_BITS-1:0] OP_SH  = 6'd6;
   localparam logic [OP_BITS-1:0] OP_SW  = 6'd7;

   // addr[17:16] value that marks the UART / IO window
   localparam logic [1:0] IO_SPACE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DATA_RD = 3'd1,
      S_DATA_WR = 3'd2,
      S_INST_RD = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Number of bytes moved by an access; unknown opcodes behave as words.
   function automatic logic [2:0] op_bytes(input logic [OP_BITS-1:0] op);
      logic [2:0] n;
      case (op)
         OP_LB, OP_LBU, OP_SB: n = 3'd1;
         OP_LH, OP_LHU, OP_SH: n = 3'd2;
         default:              n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/slb_mem_ctrl_ext.sv
// mem_ext_unit: sign/zero extension of an assembled little-endian load
// result according to the load opcode. Purely combinational.
module mem_ext_unit
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
) (
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] raw_i,
   output logic [DATA_W-1:0] ext_o
);

   // Select the extension by opcode; words and unknown opcodes pass through
   always_comb begin
      ext_o = raw_i;
      case (op_i)
         OP_LB:   ext_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
         OP_LBU:  ext_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
         OP_LH:   ext_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
         OP_LHU:  ext_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
         default: ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/slb_mem_ctrl.sv
// slb_mem_ctrl: serialises store/load-buffer accesses and instruction
// fetches onto an 8-bit single-port RAM, one byte per cycle, little-endian.
// Optional build macro IO_FULL_STALL_EN: stores into the IO window wait
// before each byte while io_buffer_full is high.
//
// Handshake: a requester raises its request (slb_empty_in low, or
// if_req_in high) and holds address/data stable until it sees its done
// pulse; it drops the request on the done edge. The one-cycle DONE state
// guarantees the still-high request is not accepted a second time.
module slb_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy_in,
   input  logic              slb_empty_in,
   input  logic              slb_store_in,
   input  logic [OP_W-1:0]   slb_op_in,
   input  logic [ADDR_W-1:0] slb_addr_in,
   input  logic [DATA_W-1:0] slb_data_in,
   output logic [DATA_W-1:0] slb_data_out,
   output logic              slb_done_out,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic [DATA_W-1:0] if_data_out,
   output logic              if_done_out,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   state_t            state_q;
   logic [2:0]        cnt_q;
   logic [2:0]        n_q;
   logic              inst_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] rd_d;
   logic [DATA_W-1:0] slb_data_q;
   logic [DATA_W-1:0] if_data_q;
   logic [DATA_W-1:0] ext_data;
   logic [DATA_W-1:0] wshift;
   logic              io_stall;
   logic              rd_lag;

`ifdef IO_FULL_STALL_EN
   assign io_stall = (addr_q[17:16] == IO_SPACE) && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_buffer_full;
   assign io_stall  = 1'b0;
`endif

   assign wshift = wdata_q >> {cnt_q, 3'b000};

   // While frozen mid-read, re-present the previous byte's address so the
   // RAM's one-cycle-late data still matches the byte being captured when
   // rdy_in returns.
   assign rd_lag = !rdy_in && (cnt_q != 3'd0) &&
                   ((state_q == S_DATA_RD) || (state_q == S_INST_RD));

   // Drive the RAM bus from the current state and byte index
   always_comb begin
      mem_a    = '0;
      mem_wr   = 1'b0;
      mem_dout = '0;
      case (state_q)
         S_DATA_WR: begin
            mem_a    = addr_q + ADDR_W'(cnt_q);
            mem_dout = wshift[7:0];
            mem_wr   = rdy_in && !io_stall;
         end
         S_DATA_RD, S_INST_RD: begin
            mem_a = addr_q + ADDR_W'(cnt_q) - ADDR_W'(rd_lag);
         end
         default: ;
      endcase
   end

   // Merge the returning RAM byte into result byte cnt-1
   always_comb begin
      rd_d = rd_q;
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (cnt_q == 3'(b + 1)) rd_d[8*b +: 8] = mem_din;
      end
   end

   mem_ext_unit #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_ext (
      .op_i  (op_q),
      .raw_i (rd_d),
      .ext_o (ext_data)
   );

   // Controller FSM: arbitration, byte sequencing and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         inst_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         slb_data_q <= '0;
         if_data_q  <= '0;
      end else if (rdy_in) begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               rd_q  <= '0;
               if (!slb_empty_in) begin
                  addr_q  <= slb_addr_in;
                  wdata_q <= slb_data_in;
                  op_q    <= slb_op_in;
                  n_q     <= op_bytes(slb_op_in);
                  inst_q  <= 1'b0;
                  state_q <= slb_store_in ? S_DATA_WR : S_DATA_RD;
               end else if (if_req_in) begin
                  addr_q  <= if_addr_in;
                  op_q    <= OP_W'(OP_LW);
                  n_q     <= 3'd4;
                  inst_q  <= 1'b1;
                  state_q <= S_INST_RD;
               end
            end
            S_DATA_WR: begin
               if (!io_stall) begin
                  if (cnt_q == n_q - 3'd1) begin
                     cnt_q   <= '0;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            S_DATA_RD, S_INST_RD: begin
               rd_q <= rd_d;
               if (cnt_q == n_q) begin
                  cnt_q   <= '0;
                  state_q <= S_DONE;
                  if (inst_q) if_data_q  <= rd_d;
                  else        slb_data_q <= ext_data;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign slb_data_out = slb_data_q;
   assign if_data_out  = if_data_q;
   assign slb_done_out = rdy_in && (state_q == S_DONE) && !inst_q;
   assign if_done_out  = rdy_in && (state_q == S_DONE) && inst_q;

endmodule

// File: tb/tb_slb_mem_ctrl.sv
// Bench for slb_mem_ctrl: RAM model on the byte bus, a reference memory
// with load/extend rules, and a scoreboard monitor for writes and dones.
// Build with +define+IO_FULL_STALL_EN to exercise the IO stall feature.
module tb_slb_mem_ctrl;

   localparam logic [5:0] OP_LB  = 6'd0;
   localparam logic [5:0] OP_LH  = 6'd1;
   localparam logic [5:0] OP_LW  = 6'd2;
   localparam logic [5:0] OP_LBU = 6'd3;
   localparam logic [5:0] OP_LHU = 6'd4;
   localparam logic [5:0] OP_SB  = 6'd5;
   localparam logic [5:0] OP_SH  = 6'd6;
   localparam logic [5:0] OP_SW  = 6'd7;

   logic        clk = 1'b0;
   logic        rst, rdy_in, slb_empty_in, slb_store_in, if_req_in, io_buffer_full;
   logic [5:0]  slb_op_in;
   logic [31:0] slb_addr_in, slb_data_in, slb_data_out, if_addr_in, if_data_out, mem_a;
   logic        slb_done_out, if_done_out, mem_wr;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int tag      = 0;

   typedef struct {
      logic        is_inst;
      logic        chk_data;
      logic [31:0] data;
      int          done_cyc;
      int          tag;
   } resp_t;
   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   resp_t exp_q[$];
   wr_t   wr_q[$];
   logic [7:0] ref_mem [logic [31:0]];
   logic [7:0] ram [0:4095];

   slb_mem_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .rdy_in         (rdy_in),
      .slb_empty_in   (slb_empty_in),
      .slb_store_in   (slb_store_in),
      .slb_op_in      (slb_op_in),
      .slb_addr_in    (slb_addr_in),
      .slb_data_in    (slb_data_in),
      .slb_data_out   (slb_data_out),
      .slb_done_out   (slb_done_out),
      .if_req_in      (if_req_in),
      .if_addr_in     (if_addr_in),
      .if_data_out    (if_data_out),
      .if_done_out    (if_done_out),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: synchronous write, read data valid the cycle after the address
   always @(posedge clk) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr === 1'b1) ram[mem_a[11:0]] <= mem_dout;
   end

   // reference model
   function automatic int nbytes(input logic [5:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 8'h00;
   endfunction

   function automatic logic [31:0] model_word(input int n, input logic [31:0] addr);
      logic [31:0] v;
      v = 0;
      for (int k = 0; k < n; k++) v = v + (32'(ref_rd(addr + 32'(k))) << (8 * k));
      return v;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
      logic [31:0] v;
      v = model_word(nbytes(op), addr);
      if (op == OP_LB && v >= 32'd128)   v = v - 32'd256;
      if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
      return v;
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      resp_t r;
      wr_t w;
      logic [31:0] got;
      if (mem_wr === 1'b1) begin
         checks++;
         if (wr_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d got a=%h d=%h exp none", cyc, mem_a, mem_dout);
         end else begin
            w = wr_q.pop_front();
            if (mem_a !== w.a || mem_dout !== w.d || rdy_in !== 1'b1) begin
               failures++;
               $display("FAIL write cyc=%0d got a=%h d=%h rdy=%b exp a=%h d=%h rdy=1",
                        cyc, mem_a, mem_dout, rdy_in, w.a, w.d);
            end
         end
      end
      if (slb_done_out === 1'b1 || if_done_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done cyc=%0d got slb=%b if=%b exp none", cyc, slb_done_out, if_done_out);
         end else begin
            r = exp_q.pop_front();
            got = (if_done_out === 1'b1) ? if_data_out : slb_data_out;
            if ((if_done_out !== r.is_inst) || (slb_done_out === if_done_out) ||
                (r.chk_data && got !== r.data) || (r.done_cyc >= 0 && cyc != r.done_cyc)) begin
               failures++;
               $display("FAIL done tag=%0d got if=%b slb=%b data=%h cyc=%0d exp if=%b data=%h cyc=%0d",
                        r.tag, if_done_out, slb_done_out, got, cyc, r.is_inst, r.data, r.done_cyc);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_idle(input string name);
      chk({name, "_mem_a"}, mem_a, 32'h0);
      chk({name, "_mem_wr"}, 32'(mem_wr), 32'h0);
      chk({name, "_mem_dout"}, 32'(mem_dout), 32'h0);
      chk({name, "_dones"}, {30'h0, slb_done_out, if_done_out}, 32'h0);
      chk({name, "_slb_data"}, slb_data_out, 32'h0);
      chk({name, "_if_data"}, if_data_out, 32'h0);
   endtask

   task automatic wait_done(input bit inst, input int t_id);
      int t;
      t = 0;
      do begin
         tick();
         t++;
      end while (((inst ? if_done_out : slb_done_out) !== 1'b1) && t < 200);
      checks++;
      if (t >= 200) begin
         failures++;
         $display("FAIL timeout tag=%0d got no done exp done within 200 cycles", t_id);
      end
   endtask

   task automatic issue_data(input bit st, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input int extra);
      resp_t r;
      int n;
      n = nbytes(op);
      tag++;
      r.is_inst = 1'b0;
      r.tag     = tag;
      if (st) begin
         for (int k = 0; k < n; k++) begin
            wr_q.push_back('{a: addr + 32'(k), d: data[8*k +: 8]});
            ref_mem[addr + 32'(k)] = data[8*k +: 8];
         end
         r.chk_data = 1'b0;
         r.data     = 32'h0;
         r.done_cyc = cyc + n + 1 + extra;
      end else begin
         r.chk_data = 1'b1;
         r.data     = model_load(op, addr);
         r.done_cyc = cyc + n + 2 + extra;
      end
      exp_q.push_back(r);
      slb_empty_in = 1'b0;
      slb_store_in = st;
      slb_op_in    = op;
      slb_addr_in  = addr;
      slb_data_in  = data;
   endtask

   task automatic finish_req();
      slb_empty_in = 1'b1;
      if_req_in    = 1'b0;
      tick();
      chk("idle_mem_a", mem_a, 32'h0);
      chk("idle_mem_wr", 32'(mem_wr), 32'h0);
   endtask

   // pre: cycles before the freeze, frz: cycles with rdy_in low
   task automatic run_data(input bit st, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int pre, input int frz);
      issue_data(st, op, addr, data, frz);
      if (frz > 0) begin
         repeat (pre) tick();
         rdy_in = 1'b0;
         repeat (frz) tick();
         rdy_in = 1'b1;
      end
      wait_done(1'b0, tag);
      finish_req();
   endtask

   task automatic run_inst(input logic [31:0] addr);
      resp_t r;
      tag++;
      r.is_inst  = 1'b1;
      r.chk_data = 1'b1;
      r.data     = model_word(4, addr);
      r.done_cyc = cyc + 6;
      r.tag      = tag;
      exp_q.push_back(r);
      if_req_in  = 1'b1;
      if_addr_in = addr;
      wait_done(1'b1, tag);
      finish_req();
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      return 32'h400 + 32'($urandom_range(0, 63));
   endfunction

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish before 200000ns");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      resp_t r;
      logic [5:0]  op;
      logic [31:0] d;
      bit          st;
      int          sel;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      rst = 1'b1; rdy_in = 1'b1; slb_empty_in = 1'b1; slb_store_in = 1'b0;
      slb_op_in = '0; slb_addr_in = '0; slb_data_in = '0;
      if_req_in = 1'b0; if_addr_in = '0; io_buffer_full = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      // store then load
      run_data(1'b1, OP_SW, 32'h100, 32'hDEAD_BEEF, 0, 0);
      run_data(1'b0, OP_LW, 32'h100, 32'h0, 0, 0);

      // extension
      run_data(1'b1, OP_SB, 32'h200, 32'h0000_0080, 0, 0);
      run_data(1'b1, OP_SB, 32'h201, 32'h0000_00FF, 0, 0);
      run_data(1'b0, OP_LB,  32'h200, 32'h0, 0, 0);
      run_data(1'b0, OP_LBU, 32'h200, 32'h0, 0, 0);
      run_data(1'b0, OP_LH,  32'h200, 32'h0, 0, 0);
      run_data(1'b0, OP_LHU, 32'h200, 32'h0, 0, 0);

      // arbitration: both requests raised together, data wins
      run_data(1'b1, OP_SW, 32'h10, 32'hCAFE_F00D, 0, 0);
      run_data(1'b1, OP_SW, 32'h0, 32'h1357_9BDF, 0, 0);
      issue_data(1'b0, OP_LW, 32'h10, 32'h0, 0);
      tag++;
      r.is_inst = 1'b1; r.chk_data = 1'b1; r.data = model_word(4, 32'h0);
      r.done_cyc = -1; r.tag = tag;
      exp_q.push_back(r);
      if_req_in = 1'b1; if_addr_in = 32'h0;
      wait_done(1'b0, tag - 1);
      slb_empty_in = 1'b1;
      wait_done(1'b1, tag);
      finish_req();
      repeat (4) tick();

      // misaligned wrap
      run_data(1'b1, OP_SH, 32'hFFFF_FFFF, 32'h0000_1234, 0, 0);
      run_data(1'b0, OP_LHU, 32'hFFFF_FFFF, 32'h0, 0, 0);
      run_inst(32'hFFFF_FFFE);

      // rdy_in freezes mid-access
      run_data(1'b0, OP_LW, 32'h100, 32'h0, 2, 3);
      run_data(1'b1, OP_SW, 32'h104, 32'h89AB_CDEF, 2, 2);
      run_data(1'b0, OP_LW, 32'h104, 32'h0, 0, 0);

      // reset during the second byte of a store
      tag++;
      d = 32'hA1B2_C3D4;
      for (int k = 0; k < 2; k++) begin
         wr_q.push_back('{a: 32'h300 + 32'(k), d: d[8*k +: 8]});
         ref_mem[32'h300 + 32'(k)] = d[8*k +: 8];
      end
      slb_empty_in = 1'b0; slb_store_in = 1'b1; slb_op_in = OP_SW;
      slb_addr_in = 32'h300; slb_data_in = d;
      tick();
      tick();
      rst = 1'b1;
      slb_empty_in = 1'b1;
      tick();
      check_idle("rst_mid");
      rst = 1'b0;
      tick();
      run_data(1'b0, OP_LW, 32'h300, 32'h0, 0, 0);

      // IO-space store with the UART buffer full
      d = $urandom();
`ifdef IO_FULL_STALL_EN
      issue_data(1'b1, OP_SB, 32'h0003_0040, d, 4);
      io_buffer_full = 1'b1;
      repeat (5) tick();
      io_buffer_full = 1'b0;
      wait_done(1'b0, tag);
      finish_req();
`else
      issue_data(1'b1, OP_SB, 32'h0003_0040, d, 0);
      io_buffer_full = 1'b1;
      wait_done(1'b0, tag);
      io_buffer_full = 1'b0;
      finish_req();
`endif
      run_data(1'b0, OP_LBU, 32'h0003_0040, 32'h0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 11);
         if (sel >= 10) begin
            run_inst(rand_addr());
         end else begin
            op = (sel < 8) ? 6'(sel) : 6'($urandom_range(8, 63));
            st = (op >= OP_SB && op <= OP_SW) ? 1'b1 : ((op > OP_SW) ? 1'($urandom_range(0, 1)) : 1'b0);
            if ($urandom_range(0, 3) == 0) run_data(st, op, rand_addr(), $urandom(), 1, $urandom_range(1, 2));
            else                           run_data(st, op, rand_addr(), $urandom(), 0, 0);
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (5) tick();
      chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
      chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
